// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared widths and stage vector types for the 64-bit population count
//
// Purpose: constants and packed stage types used by the popcount tree,
//          its interface and its leaf counter.
// Ports:   none (package).
package popcount_pkg;

  localparam int POPCNT_DATA_W = 64;
  localparam int POPCNT_CNT_W  = 7;

  // Per-level count widths, each sized to its maximum value (4, 16, 64).
  localparam int POPCNT_L0_W = 3;
  localparam int POPCNT_L1_W = 5;
  localparam int POPCNT_L2_W = 7;

  // Number of partial counts at each level.
  localparam int POPCNT_L0_N = 16;
  localparam int POPCNT_L1_N = 4;

  typedef logic [POPCNT_L0_N-1:0][POPCNT_L0_W-1:0] l0_vec_t;
  typedef logic [POPCNT_L1_N-1:0][POPCNT_L1_W-1:0] l1_vec_t;
  typedef logic [POPCNT_L2_W-1:0]                  l2_cnt_t;

endpackage

// File: rtl/popcount_64_if.sv
// rtl/popcount_64_if.sv - operand/result bundle between a producer and the popcount unit
//
// Purpose: groups the enable, operand word and count result.
// Signals: en - pipeline advance enable, active high
//          d  - 64-bit operand word
//          q  - 7-bit number of set bits in d
// Modports: master drives en/d and reads q; slave reads en/d and drives q.
interface popcount_64_if;
  import popcount_pkg::*;

  logic                     en;
  logic [POPCNT_DATA_W-1:0] d;
  logic [POPCNT_CNT_W-1:0]  q;

  modport master (
    output en,
    output d,
    input  q
  );

  modport slave (
    input  en,
    input  d,
    output q
  );

endinterface

// File: rtl/popcount4.sv
// rtl/popcount4.sv - bit count of a 4-bit nibble
//
// Purpose: first level of the popcount adder tree.
// Ports:   a   - 4-bit input group
//          cnt - 3-bit number of set bits in a (0..4)
module popcount4
  import popcount_pkg::*;
(
  input  logic [3:0]             a,
  output logic [POPCNT_L0_W-1:0] cnt
);

  always_comb begin
    cnt = {2'b00, a[0]} + {2'b00, a[1]} + {2'b00, a[2]} + {2'b00, a[3]};
  end

endmodule

// File: rtl/popcount_64.sv
// rtl/popcount_64.sv - 64-bit population count with 0..3 pipeline stages
//
// Purpose: counts the set bits of a 64-bit word through a three-level adder
//          tree (nibble counts, 16-bit group sums, final sum). LATENCY selects
//          how many tree levels are followed by a register.
// Ports:   clk   - rising-edge clock (unused when LATENCY = 0)
//          rst_n - synchronous active-low reset, clears every stage register
//          bus   - slave side of popcount_64_if (en, d in; q out)
module popcount_64 #(
  parameter int LATENCY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  popcount_64_if.slave bus
);
  import popcount_pkg::*;

  l0_vec_t l0_cnt;  // raw nibble counts
  l0_vec_t l0_s;    // nibble counts as seen by L1 (registered or not)
  l1_vec_t l1_sum;  // raw 16-bit group sums
  l1_vec_t l1_s;    // group sums as seen by L2
  l2_cnt_t l2_sum;  // raw final count
  l2_cnt_t l2_s;    // final count as driven onto q

  if (LATENCY < 0 || LATENCY > 3) begin : g_bad_latency
    $error("popcount_64: LATENCY must be in 0..3");
  end

  // L0: one leaf counter per nibble.
  for (genvar g = 0; g < POPCNT_L0_N; g++) begin : g_l0
    popcount4 u_popcount4 (
      .a   (bus.d[4*g +: 4]),
      .cnt (l0_cnt[g])
    );
  end

  // Register after L0 only in the deepest configuration.
  if (LATENCY == 3) begin : g_l0_reg
    l0_vec_t l0_d;
    l0_vec_t l0_q;

    always_comb begin
      l0_d = l0_cnt;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        l0_q <= '0;
      end else if (bus.en) begin
        l0_q <= l0_d;
      end
    end

    assign l0_s = l0_q;
  end else begin : g_l0_comb
    assign l0_s = l0_cnt;
  end

  // L1: four nibble counts per 16-bit group, widened before adding.
  always_comb begin
    l1_sum = '0;
    for (int j = 0; j < POPCNT_L1_N; j++) begin
      l1_sum[j] = {2'b00, l0_s[4*j]}   + {2'b00, l0_s[4*j+1]} +
                  {2'b00, l0_s[4*j+2]} + {2'b00, l0_s[4*j+3]};
    end
  end

  if (LATENCY >= 2) begin : g_l1_reg
    l1_vec_t l1_d;
    l1_vec_t l1_q;

    always_comb begin
      l1_d = l1_sum;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        l1_q <= '0;
      end else if (bus.en) begin
        l1_q <= l1_d;
      end
    end

    assign l1_s = l1_q;
  end else begin : g_l1_comb
    assign l1_s = l1_sum;
  end

  // L2: final sum of the four group sums.
  always_comb begin
    l2_sum = {2'b00, l1_s[0]} + {2'b00, l1_s[1]} +
             {2'b00, l1_s[2]} + {2'b00, l1_s[3]};
  end

  if (LATENCY >= 1) begin : g_l2_reg
    l2_cnt_t l2_d;
    l2_cnt_t l2_q;

    always_comb begin
      l2_d = l2_sum;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        l2_q <= '0;
      end else if (bus.en) begin
        l2_q <= l2_d;
      end
    end

    assign l2_s = l2_q;
  end else begin : g_l2_comb
    // Fully combinational: clock, reset and enable have no effect.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n, bus.en};
    assign l2_s        = l2_sum;
  end

  assign bus.q = l2_s;

endmodule

// File: tb/tb_popcount_64.sv
// tb/tb_popcount_64.sv - scoreboard bench running all four latencies on a shared operand
module tb_popcount_64;
  import popcount_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] d;

  always #5 clk = ~clk;

  popcount_64_if bus0 ();
  popcount_64_if bus1 ();
  popcount_64_if bus2 ();
  popcount_64_if bus3 ();

  assign bus0.d = d;  assign bus0.en = en;
  assign bus1.d = d;  assign bus1.en = en;
  assign bus2.d = d;  assign bus2.en = en;
  assign bus3.d = d;  assign bus3.en = en;

  popcount_64 #(.LATENCY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  popcount_64 #(.LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  popcount_64 #(.LATENCY(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  popcount_64 #(.LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  // Scoreboard: expected q for each latency, visible at the next falling edge.
  logic [3:0][6:0] sb_exp[$];
  int              sb_step[$];

  // Popcounts of every word taken on an enabled edge since the last reset.
  logic [6:0] samples[$];

  function automatic logic [6:0] ref_pop(input logic [63:0] w);
    int n = 0;
    for (int i = 0; i < 64; i++) if (w[i]) n++;
    return 7'(n);
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0:       return a & b;
      1:       return a | b;
      2:       return 64'h1 << $urandom_range(0, 63);
      default: return a;
    endcase
  endfunction

  // Apply one cycle of inputs and record what each instance must show.
  // Latency N shows the word taken N-1 enabled edges before the latest one,
  // or 0 if fewer than N enabled edges have occurred since reset.
  task automatic step(input logic [63:0] dv, input logic env, input logic rv);
    logic [3:0][6:0] e;
    d     = dv;
    en    = env;
    rst_n = rv;
    e[0]  = ref_pop(dv);
    for (int n = 1; n < 4; n++)
      e[n] = (samples.size() >= n) ? samples[samples.size() - n] : 7'd0;
    sb_exp.push_back(e);
    sb_step.push_back(step_no);
    if (!rv)      samples.delete();
    else if (env) samples.push_back(ref_pop(dv));
    step_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every instance at each falling edge that has an entry.
  initial begin
    logic [3:0][6:0] e;
    logic [3:0][6:0] got;
    int              sn;
    forever begin
      @(negedge clk);
      if (sb_exp.size() > 0) begin
        e   = sb_exp.pop_front();
        sn  = sb_step.pop_front();
        got = {bus3.q, bus2.q, bus1.q, bus0.q};
        for (int n = 0; n < 4; n++) begin
          checks++;
          if (got[n] !== e[n]) begin
            failures++;
            $display("FAIL q_lat%0d step=%0d got=%0d expected=%0d", n, sn, got[n], e[n]);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    d     = '0;
    @(posedge clk);
    #1;

    // Reset held for two cycles, then released.
    step(64'h0, 1'b1, 1'b0);
    step(64'h0, 1'b1, 1'b0);

    // Corner words.
    step(64'h0, 1'b1, 1'b1);
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    step(64'h8000_0000_0000_0001, 1'b1, 1'b1);
    step(64'h5555_5555_5555_5555, 1'b1, 1'b1);
    step(64'h0000_0000_0000_000F, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(64'h0, 1'b1, 1'b1);

    // Back-to-back stream right after a reset.
    step(64'h0, 1'b1, 1'b0);
    step(64'h0, 1'b1, 1'b1);
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    step(64'h1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(64'h0, 1'b1, 1'b1);

    // Enable hold: d changes during the hold but must not be taken.
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(rand_word(), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(64'h0, 1'b1, 1'b1);

    // Reset mid-stream with all-ones fed continuously.
    for (int i = 0; i < 4; i++) step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Reset asserted while en is low must still clear.
    step(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    step(64'h0, 1'b0, 1'b1);

    // Random words, continuous enable.
    for (int i = 0; i < 1000; i++) step(rand_word(), 1'b1, 1'b1);

    // Random words with enable gaps and occasional resets.
    for (int i = 0; i < 200; i++)
      step(rand_word(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) != 0));

    for (int i = 0; i < 4; i++) step(64'h0, 1'b1, 1'b1);

    @(negedge clk);
    #1;
    checks++;
    if (sb_exp.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_exp.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
